// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment display blocks.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'h3F;

    localparam logic [3:0] AN_OFF = 4'hF;

    // Frame snapshot: everything the decoder is allowed to look at.
    typedef struct packed {
        logic        lz;
        logic [3:0]  dp;
        logic [15:0] bcd;
    } shadow_t;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD nibble to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (nibble)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// 4-digit multiplexed 7-segment driver with per-slot blanking, leading-zero
// suppression and a once-per-frame input snapshot. All outputs registered.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_blank,
    output logic [3:0]  an,
    output logic [6:0]  cath,
    output logic        dp,
    output logic        frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    shadow_t       shadow_q, shadow_d;
    logic [3:0]    an_q, an_d;
    seg_t          cath_q, cath_d;
    logic          dp_q, dp_d;
    logic          frame_start_q, frame_start_d;

    logic       snap;
    logic       upper_zero;
    logic       lz_hide;
    logic       blank_ph;
    logic [3:0] nib;
    seg_t       seg_raw;

    bcd_to_seg u_dec (
        .nibble (nib),
        .seg    (seg_raw)
    );

    always_comb begin
        snap     = (cnt_q == '0) && (idx_q == 2'd0);
        cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        idx_d    = (cnt_q == CNT_MAX) ? idx_q + 2'd1 : idx_q;
        shadow_d = shadow_q;
        if (snap) begin
            shadow_d.lz  = lz_blank;
            shadow_d.dp  = dp_in;
            shadow_d.bcd = bcd_in;
        end

        // Decode from the value being latched so a zero-length blank still
        // shows the fresh snapshot on the very first drive cycle.
        nib = shadow_d.bcd[{idx_q, 2'b00} +: 4];

        upper_zero = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(idx_q) && shadow_d.bcd[k*4 +: 4] != 4'h0)
                upper_zero = 1'b0;
        end
        lz_hide  = shadow_d.lz && (idx_q != 2'd0) && upper_zero;
        blank_ph = int'(cnt_q) < BLANK_CYCLES;

        if (blank_ph || lz_hide) begin
            an_d   = AN_OFF;
            cath_d = SEG_BLANK;
            dp_d   = 1'b1;
        end else begin
            an_d   = ~(4'b0001 << idx_q);
            cath_d = seg_raw;
            dp_d   = ~shadow_d.dp[idx_q];
        end
        frame_start_d = snap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            shadow_q      <= '0;
            an_q          <= AN_OFF;
            cath_q        <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            an_q          <= an_d;
            cath_q        <= cath_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign cath        = cath_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: directed scenarios plus random traffic, each cycle
// compared against a frame/slot arithmetic model of the display.
module tb_seg_scan_mux;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  cath;
    logic        dp;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    seg_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .reset       (reset),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .lz_blank    (lz_blank),
        .an          (an),
        .cath        (cath),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10];
    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    end

    // Model state: cycles since reset release, and the frame's latched inputs.
    int          t = 0;
    logic [15:0] s_bcd = '0;
    logic [3:0]  s_dp = '0;
    logic        s_lz = 1'b0;
    logic [12:0] exp_v;

    task automatic tick(input string tag);
        int pos, slot, c;
        logic lit;
        logic [3:0] dig, an_e;
        logic [6:0] seg_e;
        @(posedge clk);
        if (reset) begin
            exp_v = {4'hF, 7'h7F, 1'b1, 1'b0};
            t = 0;
        end else begin
            pos  = t % (4 * RD);
            slot = pos / RD;
            c    = pos % RD;
            if (pos == 0) begin
                s_bcd = bcd_in;
                s_dp  = dp_in;
                s_lz  = lz_blank;
            end
            dig   = 4'((s_bcd >> (4 * slot)) & 16'hF);
            seg_e = (dig < 10) ? seg_tab[dig] : 7'h3F;
            an_e  = ~(4'b0001 << slot);
            lit   = (c >= BC) && !(s_lz && slot >= 1 && (s_bcd >> (4 * slot)) == 0);
            if (lit) exp_v = {an_e, seg_e, ~s_dp[slot], pos == 0};
            else     exp_v = {4'hF, 7'h7F, 1'b1, pos == 0};
            t++;
        end
        #1;
        vectors++;
        assert ({an, cath, dp, frame_start} === exp_v) else begin
            miscompares++;
            $error("FAIL %s t=%0d observed an=%b cath=%b dp=%b fs=%b expected an=%b cath=%b dp=%b fs=%b",
                   tag, t, an, cath, dp, frame_start,
                   exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bcd_in   = 16'($urandom);
            dp_in    = 4'($urandom);
            lz_blank = 1'($urandom);
            tick("reset");
        end

        bcd_in = 16'h1234; dp_in = 4'b0100; lz_blank = 1'b0;
        reset = 1'b0;
        run(64, "basic_scan");

        bcd_in = 16'h0007; dp_in = 4'b0000; lz_blank = 1'b1;
        run(64, "lz_on");
        lz_blank = 1'b0;
        run(64, "lz_off");

        bcd_in = 16'h1111;
        run(44, "coherency_old");
        bcd_in = 16'h2222;
        run(52, "coherency_new");

        bcd_in = 16'h00A0; lz_blank = 1'b1;
        run(64, "invalid_nibble");

        bcd_in = 16'h5678; dp_in = 4'b1001; lz_blank = 1'b0;
        run(20, "pre_reset");
        reset = 1'b1;
        bcd_in = 16'h9090; dp_in = 4'b0010; lz_blank = 1'b1;
        run(2, "mid_reset");
        reset = 1'b0;
        run(40, "post_reset");

        for (int r = 0; r < 40; r++) begin
            logic [15:0] mask;
            mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
            bcd_in   = 16'($urandom) & mask;
            dp_in    = 4'($urandom);
            lz_blank = 1'($urandom);
            reset    = ($urandom_range(0, 9) == 0);
            tick("random");
            reset = 1'b0;
            run($urandom_range(1, 40), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
